i2c_target_rx: RTL and testbench
================================

I2C_TARGET_RX -- requirements
Module: i2c_target_rx

Interface
REQ-001 Parameter TARGET_ADDR, default 7'h2A: 7-bit I2C address this target responds to.
REQ-002 clk  input  1  system clock; all state updates on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 scl_in  input  1  raw SCL from the bus, asynchronous to clk.
REQ-005 sda_in  input  1  raw SDA from the bus, asynchronous to clk.
REQ-006 sda_oe  output  1  when 1, external open-drain pad pulls SDA low (ACK); 0 = released.
REQ-007 rx_data  output  8  last received data byte, MSB first on the wire.
REQ-008 rx_valid  output  1  rx_data holds an unconsumed byte.
REQ-009 rx_ready  input  1  consumer accepts rx_data on a cycle where rx_valid and rx_ready are both 1.
REQ-010 overrun  output  1  one-cycle pulse: a byte was dropped because rx_valid was still set.
REQ-011 busy  output  1  1 from a detected START until the next detected STOP.

Function
REQ-012 scl_in and sda_in SHALL each pass a 2-flop synchronizer; edge and condition detection SHALL compare each synchronized sample with its value one clk earlier.
REQ-013 START: synchronized SDA falls while synchronized SCL is high. STOP: SDA rises while SCL is high. Both SHALL be honoured in every state; repeated START re-enters ADDR.
REQ-014 States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
REQ-015 IDLE -> ADDR on START; any state -> IDLE on STOP; any state -> ADDR on START.
REQ-016 Bits SHALL be sampled on the SCL rising edge; a 3-bit counter tracks bits 0..7 and wraps to 0 after each byte.
REQ-017 ADDR: after 8 bits, if bits[7:1] == TARGET_ADDR and bit0 (R/W) == 0 -> ADDR_ACK; otherwise -> IGNORE with sda_oe held 0.
REQ-018 ADDR_ACK/DATA_ACK: sda_oe SHALL go 1 on the SCL falling edge after the 8th bit and return to 0 on the next SCL falling edge; then -> DATA.
REQ-019 DATA: on the 8th rising edge, if rx_valid == 0 or rx_ready == 1 in that cycle, rx_data SHALL load the byte and rx_valid SHALL be 1 on the next clk, then -> DATA_ACK.
REQ-020 DATA: on the 8th rising edge with rx_valid == 1 and rx_ready == 0, the byte SHALL be discarded, overrun pulses for exactly one clk, no ACK is driven, -> IGNORE.
REQ-021 rx_valid SHALL clear the clk after a valid&ready transfer unless a new byte loads in that same clk, in which case it stays 1.
REQ-022 IGNORE: sda_oe held 0; only START or STOP leave this state.
REQ-023 A STOP or START mid-byte SHALL discard partial bits and force sda_oe to 0 on the next clk; a completed, pending rx_data/rx_valid SHALL be retained.
REQ-024 busy SHALL be 1 the clk after START is detected and 0 the clk after STOP is detected.

Reset
REQ-025 While reset is 1 at a clk edge: state = IDLE, bit counter = 0, sda_oe = 0, rx_data = 8'h00, rx_valid = 0, overrun = 0, busy = 0, synchronizer flops = 1 (bus idle).
REQ-026 Reset asserted mid-transaction SHALL abort it; after release the block SHALL wait in IDLE for a fresh START.

Configuration
REQ-027 Macro I2C_GLITCH_FILTER_EN defined: each synchronized line SHALL pass a 3-sample majority filter, adding 2 clk of latency and rejecting pulses shorter than 2 clk.
REQ-028 Macro I2C_GLITCH_FILTER_EN absent: no filter; detection uses the 2-flop synchronizer outputs directly. All other behaviour is identical.

Verification
REQ-029 START, address 0x2A+W, byte 0xA5, STOP, with rx_ready held 1 -> ACK on both 9th clocks; rx_data = 0xA5 with a one-clk rx_valid pulse; busy returns to 0.
REQ-030 START, address 0x2B+W -> no ACK (sda_oe stays 0), state IGNORE, rx_valid never set; STOP -> IDLE.
REQ-031 START, address 0x2A+R -> NACK, IGNORE; no data output.
REQ-032 rx_ready held 0, bytes 0x11 then 0x22 -> 0x11 ACKed and held on rx_data; 0x22 NACKed; overrun pulses once; rx_data remains 0x11.
REQ-033 START, 0x2A+W, 4 data bits, then repeated START, 0x2A+W, 0x3C -> partial byte dropped; rx_data = 0x3C.
REQ-034 reset asserted for 1 clk during the 5th data bit -> all outputs at reset values; a subsequent full write of 0x5A completes normally. With I2C_GLITCH_FILTER_EN defined, a 1-clk SCL glitch inside a bit -> no extra bit counted.

Source files
------------

// File: rtl/i2c_target_rx_if.sv
// Bus and consumer signals of the receive-only I2C target, bundled as one port.
// The target (DUT) uses the slave modport. The bus master and byte consumer use master.
interface i2c_target_rx_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       overrun;
    logic       busy;

    modport slave (
        input  scl_in, sda_in, rx_ready,
        output sda_oe, rx_data, rx_valid, overrun, busy
    );

    modport master (
        output scl_in, sda_in, rx_ready,
        input  sda_oe, rx_data, rx_valid, overrun, busy
    );
endinterface

// File: rtl/i2c_target_rx.sv
// Receive-only I2C target: synchronizes SCL/SDA, detects START/STOP, matches a
// 7-bit write address, ACKs accepted bytes and hands them out on a valid/ready port.
// A byte that arrives while the previous one is still unconsumed is dropped:
// overrun pulses and the rest of the transfer is ignored.
// Optional feature: define I2C_GLITCH_FILTER_EN to add a 3-sample majority filter
// on each synchronized line. This adds 2 clk of latency and rejects 1-clk pulses.
module i2c_target_rx #(
    parameter logic [6:0] TARGET_ADDR = 7'h2A
) (
    input  logic           clk,
    input  logic           reset,
    i2c_target_rx_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_IGNORE
    } state_t;

    state_t     r_state, w_state_nxt;
    logic       r_scl_s1, r_scl_s2, r_sda_s1, r_sda_s2;
    logic       w_scl, w_sda;
    logic       r_scl_d, r_sda_d;
    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;
    logic [7:0] w_byte;
    logic       w_byte_done, w_accept;
    logic       w_load, w_drop, w_sda_oe_nxt;
    logic       r_sda_oe, r_rx_valid, r_overrun, r_busy;
    logic [7:0] r_rx_data;

    // Two-flop synchronizers. They reset to the idle-bus level so that reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_s1 <= 1'b1;
            r_scl_s2 <= 1'b1;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge values, so the chain really is two stages.
            r_scl_s1 <= bus.scl_in;
            r_scl_s2 <= r_scl_s1;
            r_sda_s1 <= bus.sda_in;
            r_sda_s2 <= r_sda_s1;
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] r_scl_hist, r_sda_hist;
    logic       r_scl_filt, r_sda_filt;

    // Registered 2-of-3 majority over the current sample and the two older ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_hist <= 2'b11;
            r_sda_hist <= 2'b11;
            r_scl_filt <= 1'b1;
            r_sda_filt <= 1'b1;
        end else begin
            r_scl_hist <= {r_scl_hist[0], r_scl_s2};
            r_sda_hist <= {r_sda_hist[0], r_sda_s2};
            r_scl_filt <= (r_scl_s2 & r_scl_hist[0]) | (r_scl_s2 & r_scl_hist[1]) |
                          (r_scl_hist[0] & r_scl_hist[1]);
            r_sda_filt <= (r_sda_s2 & r_sda_hist[0]) | (r_sda_s2 & r_sda_hist[1]) |
                          (r_sda_hist[0] & r_sda_hist[1]);
        end
    end

    assign w_scl = r_scl_filt;
    assign w_sda = r_sda_filt;
`else
    assign w_scl = r_scl_s2;
    assign w_sda = r_sda_s2;
`endif

    // Keep the previous sample of each line for edge and condition detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl;
            r_sda_d <= w_sda;
        end
    end

    assign w_scl_rise  = w_scl & ~r_scl_d;
    assign w_scl_fall  = ~w_scl & r_scl_d;
    assign w_start     = w_scl & r_scl_d & r_sda_d & ~w_sda;
    assign w_stop      = w_scl & r_scl_d & ~r_sda_d & w_sda;
    assign w_byte      = {r_shift, w_sda};
    assign w_byte_done = w_scl_rise & (r_bit_cnt == 3'd7);
    assign w_accept    = ~r_rx_valid | bus.rx_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode. STOP and START take priority in every state.
    always_comb begin
        // NOTE: the default assignment comes first so every path assigns a value and no latch is inferred.
        w_state_nxt = r_state;
        if (w_stop) begin
            w_state_nxt = S_IDLE;
        end else if (w_start) begin
            w_state_nxt = S_ADDR;
        end else begin
            unique case (r_state)
                S_ADDR: if (w_byte_done)
                    w_state_nxt = (w_byte[7:1] == TARGET_ADDR && !w_byte[0]) ? S_ADDR_ACK : S_IGNORE;
                // r_sda_oe high means the ACK clock is under way. Its falling edge ends the ACK.
                S_ADDR_ACK, S_DATA_ACK: if (w_scl_fall && r_sda_oe)
                    w_state_nxt = S_DATA;
                S_DATA: if (w_byte_done)
                    w_state_nxt = w_accept ? S_DATA_ACK : S_IGNORE;
                default: w_state_nxt = r_state;  // IDLE and IGNORE wait for START/STOP
            endcase
        end
    end

    // Output decode: byte load/drop strobes and the next ACK drive level.
    always_comb begin
        w_load       = 1'b0;
        w_drop       = 1'b0;
        w_sda_oe_nxt = 1'b0;
        if (!w_start && !w_stop) begin
            unique case (r_state)
                S_DATA: begin
                    w_load = w_byte_done & w_accept;
                    w_drop = w_byte_done & ~w_accept;
                end
                // The first SCL fall turns the ACK on. The second SCL fall turns it off.
                S_ADDR_ACK, S_DATA_ACK: w_sda_oe_nxt = r_sda_oe ^ w_scl_fall;
                default: w_sda_oe_nxt = 1'b0;
            endcase
        end
    end

    // Datapath: bit shifter, output byte register, handshake and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_sda_oe   <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_overrun  <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_start || w_stop) begin
                r_bit_cnt <= '0;
            end else if (w_scl_rise && (r_state == S_ADDR || r_state == S_DATA)) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
                r_shift   <= {r_shift[5:0], w_sda};
            end
            r_sda_oe  <= w_sda_oe_nxt;
            r_overrun <= w_drop;
            if (w_load) r_rx_data <= w_byte;
            if (w_load)              r_rx_valid <= 1'b1;
            else if (bus.rx_ready)   r_rx_valid <= 1'b0;
            if (w_start)             r_busy <= 1'b1;
            else if (w_stop)         r_busy <= 1'b0;
        end
    end

    assign bus.sda_oe   = r_sda_oe;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_valid = r_rx_valid;
    assign bus.overrun  = r_overrun;
    assign bus.busy     = r_busy;

endmodule

// File: tb/tb_i2c_target_rx.sv
// Testbench for i2c_target_rx. A bit-banged I2C master drives randomized and
// directed write transfers. A transaction-level model predicts ACKs, accepted
// bytes and overruns. A monitor pops accepted bytes from the scoreboard queue.
module tb_i2c_target_rx;

    localparam logic [6:0] TGT = 7'h2A;
    localparam int         Q   = 8;   // clk cycles per quarter SCL period

    logic clk = 1'b0;
    logic reset;
    logic m_scl, m_sda;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ovr  = 0;
    int ovr_cycles = 0;
    logic [7:0] exp_q[$];
    logic       m_pending = 1'b0;
    logic [7:0] m_held = 8'h00;

    i2c_target_rx_if bus ();

    assign bus.scl_in = m_scl;
    assign bus.sda_in = m_sda & ~bus.sda_oe;   // open-drain wired-AND

    i2c_target_rx #(.TARGET_ADDR(TGT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted byte against the scoreboard, count overrun cycles.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.rx_valid && bus.rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got byte 0x%0h, none expected", bus.rx_data);
                end else begin
                    check("rx_data", {24'h0, bus.rx_data}, {24'h0, exp_q.pop_front()});
                end
            end
            if (bus.overrun) ovr_cycles++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    tick(Q);
        m_scl = 1'b1; tick(2 * Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic send_bit_glitch(input logic b);
        m_sda = b;    tick(Q);
        m_scl = 1'b1; tick(Q);
        m_scl = 1'b0; tick(1);
        m_scl = 1'b1; tick(Q - 1);
        m_scl = 1'b0; tick(Q);
    endtask

    // Ninth clock: master releases SDA, samples the target's ACK, then checks the release.
    task automatic ack_clock(output logic ack);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        ack = bus.sda_oe;
        tick(Q);
        m_scl = 1'b0; tick(Q);
        check("ack_release", {31'h0, bus.sda_oe}, 32'h0);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        ack_clock(ack);
    endtask

    // One write transfer. Expected ACKs, bytes and overruns come from the byte-level rules.
    task automatic run_write(input logic [6:0] addr, input logic rw, input logic [7:0] b0,
                             input logic [7:0] b1, input logic [7:0] b2, input int n,
                             input logic ready);
        logic [7:0] d[3];
        logic ack, exp_ack, ignoring;
        d[0] = b0; d[1] = b1; d[2] = b2;
        bus.rx_ready = ready;
        i2c_start();
        check("busy_after_start", {31'h0, bus.busy}, 32'h1);
        send_byte({addr, rw}, ack);
        exp_ack = (addr == TGT) && (rw == 1'b0);
        check("addr_ack", {31'h0, ack}, {31'h0, exp_ack});
        ignoring = !exp_ack;
        for (int i = 0; i < n; i++) begin
            if (ignoring) begin
                exp_ack = 1'b0;
            end else if (m_pending && !ready) begin
                exp_ack = 1'b0;
                exp_ovr++;
                ignoring = 1'b1;
            end else begin
                exp_ack = 1'b1;
                exp_q.push_back(d[i]);
                m_held = d[i];
                m_pending = !ready;
            end
            send_byte(d[i], ack);
            check("data_ack", {31'h0, ack}, {31'h0, exp_ack});
        end
        if (m_pending) begin
            check("held_rx_data", {24'h0, bus.rx_data}, {24'h0, m_held});
            check("held_rx_valid", {31'h0, bus.rx_valid}, 32'h1);
        end
        i2c_stop();
        tick(4);
        check("busy_after_stop", {31'h0, bus.busy}, 32'h0);
        bus.rx_ready = 1'b1;
        tick(4);
        m_pending = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sda_oe"},   {31'h0, bus.sda_oe},   32'h0);
        check({tag, "_rx_data"},  {24'h0, bus.rx_data},  32'h0);
        check({tag, "_rx_valid"}, {31'h0, bus.rx_valid}, 32'h0);
        check({tag, "_overrun"},  {31'h0, bus.overrun},  32'h0);
        check({tag, "_busy"},     {31'h0, bus.busy},     32'h0);
    endtask

    initial begin
        logic ack;
        int   ovr_before;
        logic [6:0] a;

        reset = 1'b1;
        m_scl = 1'b1;
        m_sda = 1'b1;
        bus.rx_ready = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(1);
        check_reset_outputs("reset");

        // Basic write: the address and 0xA5 are both ACKed. rx_valid pulses with ready held.
        run_write(TGT, 1'b0, 8'hA5, 8'h00, 8'h00, 1, 1'b1);
        // Wrong address and read requests are ignored.
        run_write(7'h2B, 1'b0, 8'h77, 8'h00, 8'h00, 1, 1'b1);
        run_write(TGT, 1'b1, 8'h66, 8'h00, 8'h00, 1, 1'b1);

        // Consumer stalled: the first byte is held, the second is dropped with one overrun.
        ovr_before = ovr_cycles;
        run_write(TGT, 1'b0, 8'h11, 8'h22, 8'h00, 2, 1'b0);
        check("stall_overrun_pulses", ovr_cycles - ovr_before, 32'h1);

        // Partial byte followed by a repeated START.
        bus.rx_ready = 1'b1;
        i2c_start();
        send_byte({TGT, 1'b0}, ack);
        check("abort_addr_ack", {31'h0, ack}, 32'h1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        i2c_start();
        check("rstart_busy", {31'h0, bus.busy}, 32'h1);
        send_byte({TGT, 1'b0}, ack);
        check("rstart_addr_ack", {31'h0, ack}, 32'h1);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, ack);
        check("rstart_data_ack", {31'h0, ack}, 32'h1);
        i2c_stop();
        tick(8);
        check("rstart_rx_data", {24'h0, bus.rx_data}, 32'h3C);

        // Reset pulse during the 5th data bit aborts the transfer.
        i2c_start();
        send_byte({TGT, 1'b0}, ack);
        check("rst_addr_ack", {31'h0, ack}, 32'h1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        reset = 1'b1; tick(1);
        reset = 1'b0;
        check_reset_outputs("midreset");
        tick(Q - 1);
        m_scl = 1'b0; tick(Q);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        ack_clock(ack);
        check("no_ack_after_reset", {31'h0, ack}, 32'h0);
        check("idle_after_reset_busy", {31'h0, bus.busy}, 32'h0);
        i2c_stop();
        tick(4);
        run_write(TGT, 1'b0, 8'h5A, 8'h00, 8'h00, 1, 1'b1);

        // Randomized transfers.
        for (int t = 0; t < 16; t++) begin
            a = ($urandom_range(0, 2) == 0) ? 7'($urandom) : TGT;
            run_write(a, 1'($urandom_range(0, 3) == 0), 8'($urandom), 8'($urandom),
                      8'($urandom), int'($urandom_range(1, 3)), 1'($urandom_range(0, 2) != 0));
        end

`ifdef I2C_GLITCH_FILTER_EN
        // A 1-clk SCL glitch inside a bit must not add a bit.
        bus.rx_ready = 1'b1;
        i2c_start();
        send_byte({TGT, 1'b0}, ack);
        check("glitch_addr_ack", {31'h0, ack}, 32'h1);
        exp_q.push_back(8'h96);
        for (int i = 7; i >= 0; i--) begin
            if (i == 4) send_bit_glitch(1'(8'h96 >> i));
            else        send_bit(1'(8'h96 >> i));
        end
        ack_clock(ack);
        check("glitch_data_ack", {31'h0, ack}, 32'h1);
        i2c_stop();
        tick(8);
`endif

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick(1);
        check("scoreboard_drained", exp_q.size(), 32'h0);
        check("overrun_cycles", ovr_cycles, exp_ovr);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
